// File: rtl/tilelink_ul_slave_mem_if.sv
// TileLink-UL A/D channel pair.
//   master modport: drives the A channel and d_ready, observes a_ready and the D channel.
//   slave  modport: drives a_ready and the D channel, observes the A channel and d_ready.
interface tilelink_ul_slave_mem_if #(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8
);
    // A channel
    logic                       a_valid;
    logic                       a_ready;
    logic [TL_OPCODE_WIDTH-1:0] a_opcode;
    logic [TL_PARAM_WIDTH-1:0]  a_param;
    logic [TL_ADDR_WIDTH-1:0]   a_address;
    logic [TL_SIZE_WIDTH-1:0]   a_size;
    logic [TL_STRB_WIDTH-1:0]   a_mask;
    logic [TL_DATA_WIDTH-1:0]   a_data;
    logic [TL_SOURCE_WIDTH-1:0] a_source;

    // D channel
    logic                       d_valid;
    logic                       d_ready;
    logic [TL_OPCODE_WIDTH-1:0] d_opcode;
    logic [TL_PARAM_WIDTH-1:0]  d_param;
    logic [TL_SIZE_WIDTH-1:0]   d_size;
    logic [TL_SINK_WIDTH-1:0]   d_sink;
    logic [TL_SOURCE_WIDTH-1:0] d_source;
    logic [TL_DATA_WIDTH-1:0]   d_data;
    logic                       d_error;

    modport master (
        output a_valid, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_sink, d_source, d_data, d_error,
        input  d_ready
    );
endinterface

// File: rtl/tilelink_ul_slave_mem.sv
// TileLink-UL memory slave: word-addressed RAM behind an A/D channel pair with a
// RESP_DEPTH-entry response FIFO so requests keep flowing while D is stalled.
// Supports Get / PutFullData / PutPartialData; out-of-range, misaligned,
// oversized and unsupported requests get an error response and bump err_count.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : A/D channel pair (slave modport)
//   resp_count  : number of responses currently queued
//   err_count   : saturating count of error responses generated
module tilelink_ul_slave_mem #(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter int MEM_DEPTH       = 16,
    parameter logic [TL_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int RESP_DEPTH      = 4,
    parameter logic [TL_SINK_WIDTH-1:0] SINK_ID = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    tilelink_ul_slave_mem_if.slave        bus,
    output logic [$clog2(RESP_DEPTH):0]   resp_count,
    output logic [15:0]                   err_count
);
    localparam int OFF_W  = $clog2(TL_STRB_WIDTH);
    localparam int LANE_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int PTR_W  = $clog2(RESP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int RUN_W  = TL_STRB_WIDTH + 1;
    localparam logic [TL_ADDR_WIDTH-1:0] MEM_BYTES = TL_ADDR_WIDTH'(MEM_DEPTH * TL_STRB_WIDTH);

    localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_FULL = TL_OPCODE_WIDTH'(0);
    localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_PART = TL_OPCODE_WIDTH'(1);
    localparam logic [TL_OPCODE_WIDTH-1:0] OP_GET      = TL_OPCODE_WIDTH'(4);
    localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK      = TL_OPCODE_WIDTH'(0);
    localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK_DATA = TL_OPCODE_WIDTH'(1);

    typedef struct packed {
        logic [TL_OPCODE_WIDTH-1:0] opcode;
        logic [TL_SIZE_WIDTH-1:0]   size;
        logic [TL_SOURCE_WIDTH-1:0] source;
        logic [TL_DATA_WIDTH-1:0]   data;
        logic                       error;
    } resp_t;

    logic [TL_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    resp_t                    q   [RESP_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    // request decode
    logic [TL_ADDR_WIDTH-1:0] off, align_mask;
    logic                     size_ok, aligned, in_range, is_put, is_get, legal;
    logic [IDX_W-1:0]         word_idx;
    logic [LANE_W-1:0]        lane_off;
    logic [RUN_W-1:0]         run;
    logic [TL_STRB_WIDTH-1:0] lane_mask, wr_be;
    logic                     push, pop, full, d_valid_i;
    resp_t                    new_resp, head;

    always_comb begin
        off        = bus.a_address - BASE_ADDR;
        size_ok    = (bus.a_size <= TL_SIZE_WIDTH'(OFF_W));
        // Only meaningful when size_ok; an oversized shift just yields garbage
        // that legal masks off.
        align_mask = (TL_ADDR_WIDTH'(1) << bus.a_size) - TL_ADDR_WIDTH'(1);
        aligned    = ((bus.a_address & align_mask) == '0);
        // BASE_ADDR is aligned to the window size, so checking the offset
        // against the window cannot overflow at the top of the address space.
        in_range   = (bus.a_address >= BASE_ADDR) && (off < MEM_BYTES);
        is_put     = (bus.a_opcode == OP_PUT_FULL) || (bus.a_opcode == OP_PUT_PART);
        is_get     = (bus.a_opcode == OP_GET);
        legal      = size_ok && aligned && in_range && (is_put || is_get);
        word_idx   = IDX_W'(off >> OFF_W);
        lane_off   = LANE_W'(off & TL_ADDR_WIDTH'(TL_STRB_WIDTH - 1));
        // run = 2^a_size contiguous ones, then slid to the starting lane
        run        = (RUN_W'(1) << (32'd1 << bus.a_size)) - RUN_W'(1);
        lane_mask  = TL_STRB_WIDTH'(run) << lane_off;
    end

    assign full      = (count == CNT_W'(RESP_DEPTH));
    assign d_valid_i = (count != '0);
    assign push      = bus.a_valid && !full;
    assign pop       = d_valid_i && bus.d_ready;
    assign wr_be     = (push && legal && is_put && !rst) ? (bus.a_mask & lane_mask) : '0;

    always_comb begin
        new_resp        = '0;
        new_resp.opcode = is_get ? OP_ACK_DATA : OP_ACK;
        new_resp.size   = bus.a_size;
        new_resp.source = bus.a_source;
        new_resp.error  = !legal;
        // Whole word is returned; bytes outside the lane mask come back as stored.
        if (legal && is_get)
            new_resp.data = mem[word_idx];
    end

    // RAM and queue payload carry no reset: a reset only clears the pointers.
    always_ff @(posedge clk) begin
        for (int b = 0; b < TL_STRB_WIDTH; b++) begin
            if (wr_be[b])
                mem[word_idx][8*b +: 8] <= bus.a_data[8*b +: 8];
        end
        if (push && !rst)
            q[wr_ptr] <= new_resp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && !legal && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
        end
    end

    assign head = q[rd_ptr];

    // D fields are forced to zero while the queue is empty so the reset state
    // is clean even though queue storage is not reset.
    assign bus.a_ready  = !full;
    assign bus.d_valid  = d_valid_i;
    assign bus.d_opcode = d_valid_i ? head.opcode : '0;
    assign bus.d_param  = '0;
    assign bus.d_size   = d_valid_i ? head.size   : '0;
    assign bus.d_sink   = SINK_ID;
    assign bus.d_source = d_valid_i ? head.source : '0;
    assign bus.d_data   = d_valid_i ? head.data   : '0;
    assign bus.d_error  = d_valid_i ? head.error  : 1'b0;
    assign resp_count   = count;

    logic unused_bits;
    assign unused_bits = ^{bus.a_param, run[TL_STRB_WIDTH]};
endmodule
